// File: rtl/multi_channel_timer_if.sv
// Bundle between a timer block and its controller: per-channel
// arm/cancel/ack controls in, status and interrupt summary out.
interface multi_channel_timer_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
);
   localparam int IDW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0]       start;
   logic [CHANNELS-1:0]       cancel;
   logic [CHANNELS*WIDTH-1:0] period;
   logic [CHANNELS-1:0]       periodic;
   logic [CHANNELS-1:0]       ack;
   logic [CHANNELS-1:0]       busy;
   logic [CHANNELS*WIDTH-1:0] count;
   logic [CHANNELS-1:0]       expire;
   logic [CHANNELS-1:0]       pending;
   logic                      irq;
   logic [IDW-1:0]            irq_id;

   modport master (
      output start, cancel, period, periodic, ack,
      input  busy, count, expire, pending, irq, irq_id
   );

   modport slave (
      input  start, cancel, period, periodic, ack,
      output busy, count, expire, pending, irq, irq_id
   );
endinterface

// File: rtl/multi_channel_timer.sv
// Independent countdown channels with one-shot/periodic modes,
// sticky pending flags and a lowest-index interrupt summary.
module multi_channel_timer #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   multi_channel_timer_if.slave bus
);
   localparam int IDW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   logic [CHANNELS-1:0]       busy_v;
   logic [CHANNELS-1:0]       exp_v;
   logic [CHANNELS-1:0]       pend_v;
   logic [CHANNELS*WIDTH-1:0] cnt_v;
   logic [IDW-1:0]            id_v;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t           st;
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] reload;
      logic             mode;
      logic             pend;
      logic [WIDTH-1:0] per_in;

      assign per_in   = bus.period[i*WIDTH +: WIDTH];
      assign exp_v[i] = (st == RUN) && (cnt == WIDTH'(1))
                        && !bus.cancel[i];

      always_ff @(posedge clk) begin
         if (reset) begin
            st     <= IDLE;
            cnt    <= '0;
            reload <= '0;
            mode   <= 1'b0;
            pend   <= 1'b0;
         end else begin
            // expiry sets pending even if ack arrives the same cycle
            if (exp_v[i])
               pend <= 1'b1;
            else if (bus.ack[i])
               pend <= 1'b0;

            if (bus.cancel[i]) begin
               st  <= IDLE;
               cnt <= '0;
            end else if (bus.start[i]) begin
               st     <= RUN;
               cnt    <= per_in;
               reload <= per_in;
               mode   <= bus.periodic[i];
            end else if (st == RUN) begin
               if (exp_v[i]) begin
                  if (mode) begin
                     cnt <= reload;
                  end else begin
                     st  <= IDLE;
                     cnt <= '0;
                  end
               end else begin
                  cnt <= cnt - WIDTH'(1);
               end
            end
         end
      end

      assign busy_v[i]               = (st == RUN);
      assign pend_v[i]               = pend;
      assign cnt_v[i*WIDTH +: WIDTH] = cnt;
   end

   always_comb begin
      id_v = '0;
      for (int k = CHANNELS - 1; k >= 0; k--)
         if (pend_v[k]) id_v = IDW'(k);
   end

   assign bus.busy    = busy_v;
   assign bus.count   = cnt_v;
   assign bus.expire  = exp_v;
   assign bus.pending = pend_v;
   assign bus.irq     = |pend_v;
   assign bus.irq_id  = id_v;
endmodule
